// File: rtl/stereo_pkg.sv
// Constants and types shared by the frame-buffer write path and the VGA read controller.
package stereo_pkg;

  // 320x240 frame buffer, y*H_RES+x linear map.
  localparam int unsigned H_RES  = 320;
  localparam int unsigned V_RES  = 240;
  localparam int unsigned ADDR_W = 17;

  // Capture FSM. SYNC discards whatever partial frame is in flight after reset.
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2
  } capture_state_t;

endpackage

// File: rtl/rgb565_byte_packer.sv
// Packs the OV7670 two-byte RGB565 stream into 16-bit pixels.
// The first byte of each pair is latched; the pixel is presented combinationally
// with the second byte so the caller can register it on the same edge.
module rgb565_byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  byte_in,
  output logic        pixel_valid,
  output logic [15:0] pixel,
  output logic        phase
);

  logic       phase_q;
  logic [7:0] hi_q;

  // Phase toggles on every enabled byte and is forced back to 0 when the stream pauses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else begin
      phase_q <= enable ? ~phase_q : 1'b0;
      if (enable && !phase_q) begin
        hi_q <= byte_in;
      end
    end
  end

  assign pixel_valid = enable & phase_q;
  assign pixel       = {hi_q, byte_in};
  // A 1 while the stream is paused means a first byte was left without its partner.
  assign phase       = phase_q;

endmodule

// File: rtl/qvga_capture_writer.sv
// Camera-side writer for the stereo frame buffer: follows vsync/href, packs RGB565 pixels
// and issues one registered write per pixel at line_base + x. line_base is an accumulator
// (+H_RES per line, or -H_RES from the last row when FLIP_V is set), so no multiplier.
module qvga_capture_writer #(
  parameter int unsigned H_RES  = stereo_pkg::H_RES,
  parameter int unsigned V_RES  = stereo_pkg::V_RES,
  parameter int unsigned ADDR_W = stereo_pkg::ADDR_W,
  parameter int unsigned FLIP_V = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        cam_data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              line_err
);

  import stereo_pkg::*;

  localparam int unsigned       XW       = $clog2(H_RES + 1);
  localparam int unsigned       YW       = $clog2(V_RES + 1);
  localparam logic [XW-1:0]     XMax     = XW'(H_RES);
  localparam logic [YW-1:0]     YMax     = YW'(V_RES);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] BaseInit = (FLIP_V != 0) ? ADDR_W'((V_RES - 1) * H_RES) : '0;

  capture_state_t state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              err_q, err_d;
  logic              href_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;

  logic        pack_en;
  logic        pixel_valid;
  logic [15:0] pixel;
  logic        pending_hi;
  logic        line_end;

  assign pack_en  = (state_q == ACTIVE) && href;
  assign line_end = (state_q == ACTIVE) && href_q && !href;

  rgb565_byte_packer u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (pack_en),
    .byte_in     (cam_data),
    .pixel_valid (pixel_valid),
    .pixel       (pixel),
    .phase       (pending_hi)
  );

  // Next-state: frame FSM, x/y/line_base counters, error flag and the write-port registers.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      SYNC: begin
        if (vsync) state_d = VBLANK;
      end

      VBLANK: begin
        if (!vsync) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          base_d  = BaseInit;
          err_d   = 1'b0;
        end
      end

      ACTIVE: begin
        if (pixel_valid) begin
          if ((x_q < XMax) && (y_q < YMax)) begin
            we_d   = 1'b1;
            addr_d = base_q + ADDR_W'(x_q);
            data_d = pixel;
          end else begin
            err_d = 1'b1;
          end
          // x keeps counting past a dropped row so the line still registers at href fall.
          if (x_q < XMax) x_d = x_q + XW'(1);
        end

        if (line_end) begin
          if (x_q != '0) begin
            if (y_q < YMax) begin
              y_d    = y_q + YW'(1);
              base_d = (FLIP_V != 0) ? (base_q - LineStep) : (base_q + LineStep);
            end
            if (x_q < XMax) err_d = 1'b1;
          end
          if (pending_hi) err_d = 1'b1;
          x_d = '0;
        end

        // A write decided this cycle still goes out; y_d already folds in a same-cycle line end.
        if (vsync) begin
          state_d = VBLANK;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          if (y_d < YMax) err_d = 1'b1;
        end
      end

      default: state_d = SYNC;
    endcase
  end

  // State and output registers; reset drops any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SYNC;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
      href_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      err_q   <= err_d;
      href_q  <= href;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign we         = we_q;
  assign wAddr      = addr_q;
  assign wData      = data_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;
  assign line_err   = err_q;

endmodule

// File: tb/tb_qvga_capture_writer.sv
// Directed bench: a small 8x4 instance for packing/timing/error cases and a full-size
// FLIP_V=1 instance on the same camera inputs for the mirrored addressing.
module tb_qvga_capture_writer;

  logic       clk;
  logic       reset_n;
  logic       vsync;
  logic       href;
  logic [7:0] cam_data;

  logic        s_we, s_done, s_err;
  logic [5:0]  s_addr;
  logic [15:0] s_data;
  logic [7:0]  s_cnt;

  logic        f_we, f_done, f_err;
  logic [16:0] f_addr;
  logic [15:0] f_data;
  logic [7:0]  f_cnt;

  int checks   = 0;
  int failures = 0;

  int s_addr_q[$];
  int s_data_q[$];
  int f_addr_q[$];
  int s_done_n = 0;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       exp_we;
    int         exp_addr;
    int         exp_data;
  } vec_t;

  vec_t vecs[9];

  qvga_capture_writer #(
    .H_RES  (8),
    .V_RES  (4),
    .ADDR_W (6),
    .FLIP_V (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .href       (href),
    .cam_data   (cam_data),
    .we         (s_we),
    .wAddr      (s_addr),
    .wData      (s_data),
    .frame_done (s_done),
    .frame_cnt  (s_cnt),
    .line_err   (s_err)
  );

  qvga_capture_writer #(
    .H_RES  (320),
    .V_RES  (240),
    .ADDR_W (17),
    .FLIP_V (1)
  ) dut_flip (
    .clk        (clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .href       (href),
    .cam_data   (cam_data),
    .we         (f_we),
    .wAddr      (f_addr),
    .wData      (f_data),
    .frame_done (f_done),
    .frame_cnt  (f_cnt),
    .line_err   (f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (s_we) begin
      s_addr_q.push_back(int'(s_addr));
      s_data_q.push_back(int'(s_data));
    end
    if (s_done) s_done_n++;
    if (f_we) f_addr_q.push_back(int'(f_addr));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
    href = 1'b1; cam_data = hi; tick();
    cam_data = lo; tick();
  endtask

  task automatic end_line();
    href = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_line(input int npix, input int line);
    for (int i = 0; i < npix; i++) send_pixel(8'(line), 8'(i));
    end_line();
  endtask

  initial begin
    int bad;
    int base_n;
    int done_before;

    vecs[0] = '{8'hF8, 8'h00, 1'b1, 0, 'hF800};
    vecs[1] = '{8'h07, 8'hE0, 1'b1, 1, 'h07E0};
    vecs[2] = '{8'h00, 8'h1F, 1'b1, 2, 'h001F};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 3, 'hFFFF};
    vecs[4] = '{8'hA5, 8'h5A, 1'b1, 4, 'hA55A};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 5, 'h1234};
    vecs[6] = '{8'h56, 8'h78, 1'b1, 6, 'h5678};
    vecs[7] = '{8'h9A, 8'hBC, 1'b1, 7, 'h9ABC};
    vecs[8] = '{8'hDE, 8'hAD, 1'b0, 0, 0};

    reset_n = 1'b0; vsync = 1'b0; href = 1'b0; cam_data = 8'h00;
    repeat (3) tick();
    check("rst_we", int'(s_we), 0);
    check("rst_waddr", int'(s_addr), 0);
    check("rst_wdata", int'(s_data), 0);
    check("rst_frame_done", int'(s_done), 0);
    check("rst_frame_cnt", int'(s_cnt), 0);
    check("rst_line_err", int'(s_err), 0);
    reset_n = 1'b1;
    tick();

    // Frame with no preceding vsync is discarded.
    for (int l = 0; l < 4; l++) send_line(8, l);
    check("sync_no_writes", s_addr_q.size(), 0);
    vsync = 1'b1; repeat (3) tick();
    check("sync_no_done", s_done_n, 0);
    check("sync_cnt", int'(s_cnt), 0);
    vsync = 1'b0; repeat (2) tick();

    // Full small frame.
    s_addr_q.delete(); s_data_q.delete(); f_addr_q.delete();
    for (int l = 0; l < 4; l++) send_line(8, l);
    vsync = 1'b1; tick(); tick();
    check("full_writes", s_addr_q.size(), 32);
    bad = 0;
    for (int i = 0; i < s_addr_q.size(); i++) begin
      if (s_addr_q[i] != i || s_data_q[i] != (((i / 8) << 8) | (i % 8))) bad++;
    end
    check("full_order_errors", bad, 0);
    if (s_addr_q.size() > 0) check("full_last_addr", s_addr_q[s_addr_q.size() - 1], 31);
    check("full_done_pulses", s_done_n, 1);
    check("full_frame_cnt", int'(s_cnt), 1);
    check("full_line_err", int'(s_err), 0);
    check("flip_writes_small", f_addr_q.size(), 32);
    if (f_addr_q.size() > 8) begin
      check("flip_line0_addr", f_addr_q[0], 76480);
      check("flip_line1_addr", f_addr_q[8], 76160);
    end
    vsync = 1'b0; repeat (2) tick();

    // Table: packing, one-cycle latency, overflow pixel on line 0.
    for (int i = 0; i < 9; i++) begin
      href = 1'b1; cam_data = vecs[i].hi; tick();
      check($sformatf("tbl_we_ph0_%0d", i), int'(s_we), 0);
      cam_data = vecs[i].lo; tick();
      check($sformatf("tbl_we_%0d", i), int'(s_we), int'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check($sformatf("tbl_addr_%0d", i), int'(s_addr), vecs[i].exp_addr);
        check($sformatf("tbl_data_%0d", i), int'(s_data), vecs[i].exp_data);
      end
    end
    end_line();
    check("long_line_err", int'(s_err), 1);

    // 7-byte line: 3 pixels on row 1, trailing byte dropped.
    base_n = s_addr_q.size();
    href = 1'b1;
    for (int b = 0; b < 7; b++) begin
      cam_data = 8'(8'h10 + b);
      tick();
    end
    end_line();
    check("odd_line_writes", s_addr_q.size() - base_n, 3);
    if (s_addr_q.size() >= base_n + 3) begin
      check("odd_first_addr", s_addr_q[base_n], 8);
      check("odd_first_data", s_data_q[base_n], 'h1011);
      check("odd_last_addr", s_addr_q[base_n + 2], 10);
      check("odd_last_data", s_data_q[base_n + 2], 'h1415);
    end
    vsync = 1'b1; tick(); tick();
    check("short_frame_cnt", int'(s_cnt), 2);
    check("err_held_vblank", int'(s_err), 1);
    vsync = 1'b0; tick(); tick();
    check("err_cleared", int'(s_err), 0);

    // Mirrored addressing over a full 240-line frame (1 pixel per line).
    f_addr_q.delete();
    for (int l = 0; l < 240; l++) begin
      send_pixel(8'hAA, 8'h55);
      end_line();
    end
    check("flip_writes", f_addr_q.size(), 240);
    if (f_addr_q.size() == 240) begin
      check("flip_first", f_addr_q[0], 76480);
      check("flip_second", f_addr_q[1], 76160);
      check("flip_last", f_addr_q[239], 0);
    end
    vsync = 1'b1; tick(); tick();
    check("flip_frame_cnt", int'(f_cnt), 3);
    vsync = 1'b0; tick(); tick();

    // Reset mid-line: write dropped at once, then resync needed.
    send_pixel(8'h01, 8'h02);
    send_pixel(8'h03, 8'h04);
    check("pre_rst_we", int'(s_we), 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_we", int'(s_we), 0);
    check("async_rst_cnt", int'(s_cnt), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    s_addr_q.delete(); s_data_q.delete();
    done_before = s_done_n;
    for (int i = 0; i < 3; i++) send_pixel(8'h05, 8'(i));
    end_line();
    for (int l = 1; l < 4; l++) send_line(8, l);
    vsync = 1'b1; repeat (3) tick();
    check("post_rst_no_writes", s_addr_q.size(), 0);
    check("post_rst_no_done", s_done_n - done_before, 0);
    check("post_rst_cnt", int'(s_cnt), 0);
    vsync = 1'b0; repeat (2) tick();
    send_pixel(8'h12, 8'h34);
    check("resync_we", int'(s_we), 1);
    check("resync_addr", int'(s_addr), 0);
    check("resync_data", int'(s_data), 'h1234);
    end_line();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
